// File: rtl/wb_uart_pkg.sv
// Shared definitions for the wishbone UART TX feeder: FSM states and the slave register map.
package wb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    REQ,
    WAIT_ACK,
    GAP
  } feeder_state_e;

  localparam logic [31:0] REG_STATUS = 32'd0;
  localparam logic [31:0] REG_BAUD   = 32'd1;
  localparam logic [31:0] REG_TXDATA = 32'd2;
  localparam logic [31:0] REG_SPARE  = 32'd3;

  function automatic logic [31:0] tx_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a registered full flag and occupancy count.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   LVL_ONE    = 1;
  localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
  assign do_push = i_push && !full_q;
  assign do_pop  = i_pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d = (level_d == FULL_LEVEL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = (level_q == '0);
  assign o_level = level_q;

endmodule

// File: rtl/wb_uart_tx_feeder.sv
// Stream-to-wishbone feeder for the UART TX slave: one pipelined write per buffered byte.
// Optional start-up baud write enabled by defining WB_UART_FEEDER_BAUD_INIT_EN.
module wb_uart_tx_feeder
  import wb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] TX_ADDR     = REG_TXDATA,
  parameter logic [31:0] BAUD_ADDR   = REG_BAUD,
  parameter logic [31:0] BAUD_INIT   = 32'd115200,
  parameter int unsigned GAP_CYCLES  = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_s_valid,
  input  logic [7:0]                    i_s_data,
  output logic                          o_s_ready,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [31:0]                   o_wb_addr,
  output logic [31:0]                   o_wb_data,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_stall,
  input  logic [31:0]                   i_wb_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_err,
  output logic                          o_idle
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

`ifdef WB_UART_FEEDER_BAUD_INIT_EN
  localparam feeder_state_e RST_STATE = INIT;
`else
  localparam feeder_state_e RST_STATE = IDLE;
`endif

  feeder_state_e state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          unused_ok;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_s_valid),
    .i_data  (i_s_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = TX_ADDR;
          data_d   = tx_word(fifo_rdata);
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_d     = 1'b1;
          state_d  = REQ;
        end
      end
`ifdef WB_UART_FEEDER_BAUD_INIT_EN
      INIT: begin
        addr_d  = BAUD_ADDR;
        data_d  = BAUD_INIT;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        state_d = REQ;
      end
`endif
      REQ: begin
        if (!i_wb_stall) begin
          stb_d     = 1'b0;
          we_d      = 1'b0;
          tmo_cnt_d = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          cyc_d     = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Abort: the byte is dropped and the usual gap still applies before the next write.
          cyc_d     = 1'b0;
          err_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= RST_STATE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign o_s_ready = !fifo_full;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_err     = err_q;
  assign o_idle    = (state_q == IDLE) && fifo_empty;

`ifdef WB_UART_FEEDER_BAUD_INIT_EN
  assign unused_ok = ^i_wb_data;
`else
  assign unused_ok = ^{i_wb_data, BAUD_ADDR, BAUD_INIT};
`endif

endmodule

// File: tb/tb_wb_uart_tx_feeder.sv
// Scoreboard bench for wb_uart_tx_feeder with a behavioural wishbone slave (stall/busy/ack model).
module tb_wb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 3;
  localparam int unsigned TMO   = 15;
  localparam logic [31:0] TXA   = 32'h2;
  localparam logic [31:0] BDA   = 32'h1;
  localparam logic [31:0] BDI   = 32'd115200;
`ifdef WB_UART_FEEDER_BAUD_INIT_EN
  localparam logic IDLE_AFTER_RST = 1'b0;
`else
  localparam logic IDLE_AFTER_RST = 1'b1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_s_valid;
  logic [7:0]  i_s_data;
  logic        o_s_ready;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;
  logic [4:0]  o_fifo_level;
  logic        o_err, o_idle;

  wb_uart_tx_feeder #(
    .FIFO_DEPTH  (DEPTH),
    .TX_ADDR     (TXA),
    .BAUD_ADDR   (BDA),
    .BAUD_INIT   (BDI),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_s_valid    (i_s_valid),
    .i_s_data     (i_s_data),
    .o_s_ready    (o_s_ready),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .i_wb_ack     (i_wb_ack),
    .i_wb_stall   (i_wb_stall),
    .i_wb_data    (i_wb_data),
    .o_fifo_level (o_fifo_level),
    .o_err        (o_err),
    .o_idle       (o_idle)
  );

  initial forever #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] exp_q[$];

  // Slave model knobs and monitor state.
  bit          force_stall = 0;
  bit          no_ack = 0;
  int unsigned busy_len = 0;
  int unsigned ack_delay = 1;
  int unsigned busy_cnt = 0;
  int unsigned ack_wait = 0;
  bit          pend_ack = 0;
  int unsigned writes = 0;
  int unsigned stall_hold_cnt = 0;
  int unsigned cur_len = 0, last_cyc_len = 0, low_len = 0;
  bit          prev_cyc = 0, seen_fall = 0, prev_held = 0;
  logic [31:0] held_addr = '0, held_data = '0;
  int unsigned cyc_n = 0, acc_cyc = 0, err_cyc = 0, err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    logic [63:0] e;
    @(negedge i_clk);
    cyc_n++;
    if (o_wb_cyc) begin
      if (!prev_cyc && seen_fall) check_eq("gap_len_ok", 32'(low_len >= GAP), 1);
      cur_len++;
    end else begin
      if (prev_cyc) begin
        last_cyc_len = cur_len;
        cur_len      = 0;
        low_len      = 0;
        seen_fall    = 1;
      end
      low_len++;
    end
    prev_cyc = o_wb_cyc;
    if (i_rst) begin
      i_wb_ack   = 0;
      i_wb_stall = 0;
      pend_ack   = 0;
      busy_cnt   = 0;
      prev_held  = 0;
    end else begin
      i_wb_ack = 0;
      if (pend_ack) begin
        if (ack_wait == 0) begin
          i_wb_ack = 1;
          pend_ack = 0;
        end else ack_wait--;
      end
      if (busy_cnt > 0) busy_cnt--;
      i_wb_stall = force_stall || (busy_cnt > 0);
      if (o_err) begin
        err_cnt++;
        err_cyc = cyc_n;
      end
      if (o_wb_stb) begin
        if (i_wb_stall) begin
          if (prev_held) begin
            check_eq("stall_addr_stable", o_wb_addr, held_addr);
            check_eq("stall_data_stable", o_wb_data, held_data);
          end
          held_addr = o_wb_addr;
          held_data = o_wb_data;
          prev_held = 1;
          stall_hold_cnt++;
        end else begin
          prev_held = 0;
          check_eq("wr_we", 32'(o_wb_we), 1);
          check_eq("wr_cyc", 32'(o_wb_cyc), 1);
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_write", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("wr_addr", o_wb_addr, e[63:32]);
            check_eq("wr_data", o_wb_data, e[31:0]);
          end
          writes++;
          acc_cyc = cyc_n;
          if (!no_ack) begin
            pend_ack = 1;
            ack_wait = ack_delay;
          end
          busy_cnt = busy_len;
        end
      end else prev_held = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b, input int unsigned max_wait);
    int unsigned n = 0;
    @(negedge i_clk);
    i_s_valid = 1;
    i_s_data  = b;
    while (!o_s_ready && n < max_wait) begin
      @(negedge i_clk);
      n++;
    end
    if (o_s_ready) exp_q.push_back({TXA, 24'h0, b});
    else check_eq("push_timeout", 32'(o_s_ready), 1);
    @(posedge i_clk);
    #1 i_s_valid = 0;
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(o_idle && exp_q.size() == 0 && !pend_ack) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check_eq(tag, 32'(o_idle && exp_q.size() == 0), 1);
  endtask

  task automatic wait_stb(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!o_wb_stb && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check_eq(tag, 32'(o_wb_stb), 1);
  endtask

  task automatic expect_reset_writes();
    exp_q.delete();
`ifdef WB_UART_FEEDER_BAUD_INIT_EN
    exp_q.push_back({BDA, BDI});
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, n;
    i_rst = 1; i_s_valid = 0; i_s_data = '0; i_wb_data = '0;
    i_wb_ack = 0; i_wb_stall = 0;
    expect_reset_writes();
    repeat (2) @(negedge i_clk);
    check_eq("rst_cyc", 32'(o_wb_cyc), 0);
    check_eq("rst_stb", 32'(o_wb_stb), 0);
    check_eq("rst_we", 32'(o_wb_we), 0);
    check_eq("rst_addr", o_wb_addr, 0);
    check_eq("rst_data", o_wb_data, 0);
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_level", 32'(o_fifo_level), 0);
    check_eq("rst_ready", 32'(o_s_ready), 1);
    check_eq("rst_idle", 32'(o_idle), 32'(IDLE_AFTER_RST));
    @(negedge i_clk);
    i_rst = 0;
    wait_drain("init_drain", 200);

    // Single byte: latency and cycle length.
    push_byte(8'h55, 10);
    check_eq("t1_stb_not_yet", 32'(o_wb_stb), 0);
    @(posedge i_clk);
    #1 check_eq("t1_stb_latency", 32'(o_wb_stb), 1);
    wait_drain("t1_drain", 100);
    check_eq("t1_cyc_len", last_cyc_len, 3);

    // Busy slave: three back-to-back bytes.
    busy_len = 100;
    w0 = writes;
    stall_hold_cnt = 0;
    push_byte(8'hA1, 10);
    push_byte(8'hA2, 10);
    push_byte(8'hA3, 10);
    wait_drain("t2_drain", 600);
    check_eq("t2_writes", writes - w0, 3);
    check_eq("t2_stb_held", 32'(stall_hold_cnt > 0), 1);
    busy_len = 0;
    repeat (110) @(negedge i_clk);

    // FIFO full with a write parked in REQ.
    force_stall = 1;
    push_byte(8'h30, 10);
    wait_stb("t3_parked", 20);
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i), 10);
    check_eq("t3_level_full", 32'(o_fifo_level), 16);
    check_eq("t3_ready_low", 32'(o_s_ready), 0);
    fork
      begin
        repeat (5) @(negedge i_clk);
        check_eq("t3_refused_level", 32'(o_fifo_level), 16);
        force_stall = 0;
      end
      push_byte(8'h50, 300);
    join
    wait_drain("t3_drain", 500);

    // Ack timeout, then normal traffic.
    no_ack = 1;
    err_cnt = 0;
    push_byte(8'h77, 10);
    n = 0;
    while (err_cnt == 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("t4_err_delay", err_cyc - acc_cyc, TMO + 1);
    repeat (20) @(negedge i_clk);
    check_eq("t4_err_once", err_cnt, 1);
    no_ack = 0;
    w0 = writes;
    push_byte(8'h78, 10);
    wait_drain("t4_next_drain", 100);
    check_eq("t4_next_write", writes - w0, 1);
    check_eq("t4_next_cyc_len", last_cyc_len, 3);

    // Reset mid-request.
    force_stall = 1;
    push_byte(8'h10, 10);
    wait_stb("t5_stb", 20);
    push_byte(8'h11, 10);
    push_byte(8'h12, 10);
    check_eq("t5_level_pre", 32'(o_fifo_level), 2);
    @(negedge i_clk);
    i_rst = 1;
    #1;
    check_eq("t5_cyc_async", 32'(o_wb_cyc), 0);
    check_eq("t5_stb_async", 32'(o_wb_stb), 0);
    check_eq("t5_level_clr", 32'(o_fifo_level), 0);
    check_eq("t5_ready", 32'(o_s_ready), 1);
    expect_reset_writes();
    force_stall = 0;
    repeat (3) @(negedge i_clk);
    i_rst = 0;
    #1 check_eq("t5_idle", 32'(o_idle), 32'(IDLE_AFTER_RST));
    wait_drain("t5_drain", 200);

`ifdef WB_UART_FEEDER_BAUD_INIT_EN
    // Baud write precedes a byte queued during INIT.
    force_stall = 1;
    @(negedge i_clk);
    i_rst = 1;
    expect_reset_writes();
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    w0 = writes;
    push_byte(8'h41, 10);
    check_eq("t6_level", 32'(o_fifo_level), 1);
    force_stall = 0;
    wait_drain("t6_drain", 200);
    check_eq("t6_writes", writes - w0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
